ram_burst_writer: RTL

RAM_BURST_WRITER -- requirements
Module: ram_burst_writer

---
 rtl/ram_burst_writer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram_burst_writer.sv
// Burst writer: accepts a start address and word count, then streams
// handshaken input words into a RAM write port, one word per cycle.
module ram_burst_writer #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    // Largest burst is one full pass over the address space.
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(1 << ADDR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wraddress_q, wraddress_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              wren_q, wren_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              in_ready_c;
    logic              hs_c;
    logic [CNT_W-1:0]  len_clamp_c;

    // Ready is a pure decode so abort can suppress the handshake in-cycle.
    always_comb begin
        in_ready_c  = (state_q == WRITE) && !abort;
        hs_c        = in_valid && in_ready_c;
        len_clamp_c = (length > MAX_LEN) ? MAX_LEN : length;
    end

    // Next-state, pointer/counter update and RAM write-port staging.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        count_d     = count_q;
        wraddress_d = wraddress_q;
        wrdata_d    = wrdata_q;
        wren_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = start_addr;
                    rem_d   = len_clamp_c;
                    count_d = '0;
                    state_d = (len_clamp_c == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hs_c) begin
                    wren_d      = 1'b1;
                    wraddress_d = ptr_q;
                    wrdata_d    = in_data;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    count_d     = count_q + CNT_W'(1);
                    rem_d       = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            wraddress_q <= '0;
            wrdata_q    <= '0;
            wren_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            count_q     <= count_d;
            wraddress_q <= wraddress_d;
            wrdata_q    <= wrdata_d;
            wren_q      <= wren_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign wraddress = wraddress_q;
    assign wrdata    = wrdata_q;
    assign wren      = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule
